// File: rtl/lru_state_table.sv
// lru_state_table: per-set 8-way LRU age table with a one-stage access
// pipeline. On reset or flush an INIT sweep writes ages {7..0} (way i = i)
// to one set per cycle. An accepted request reads its set into the S1
// registers. The external age calculator returns the next ages, which are
// written back at the end of S1 when the request asked for an update.
// Optional feature: define LRU_BYPASS_EN to forward the calculator's next
// ages into the following S1 on a same-set hazard instead of stalling.
module lru_state_table #(
  parameter int SET_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [IDX_W-1:0] i_req_set,
  input  logic             i_req_hit,
  input  logic [7:0]       i_req_hit_way_8,
  input  logic             i_req_update,
  output logic [7:0]       o_hit_way_8,
  output logic             o_hit_sig,
  output logic             o_lru_write_enable,
  output logic [2:0]       o_lru_buffer0,
  output logic [2:0]       o_lru_buffer1,
  output logic [2:0]       o_lru_buffer2,
  output logic [2:0]       o_lru_buffer3,
  output logic [2:0]       o_lru_buffer4,
  output logic [2:0]       o_lru_buffer5,
  output logic [2:0]       o_lru_buffer6,
  output logic [2:0]       o_lru_buffer7,
  input  logic [2:0]       i_lru_buffer_datain0,
  input  logic [2:0]       i_lru_buffer_datain1,
  input  logic [2:0]       i_lru_buffer_datain2,
  input  logic [2:0]       i_lru_buffer_datain3,
  input  logic [2:0]       i_lru_buffer_datain4,
  input  logic [2:0]       i_lru_buffer_datain5,
  input  logic [2:0]       i_lru_buffer_datain6,
  input  logic [2:0]       i_lru_buffer_datain7,
  input  logic [7:0]       i_lru_flag,
  output logic             o_resp_valid,
  output logic [7:0]       o_resp_victim_8,
  output logic             o_init_busy
);

  typedef enum logic {INIT, RUN} state_t;

  // Way i occupies bits [3*i +: 3]; the sweep value gives way i age i.
  localparam logic [23:0] INIT_AGES = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  state_t           state;
  logic [IDX_W-1:0] sweep_cnt;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_set;
  logic [23:0]      ages_q;
  logic [23:0]      ages_mem [SET_NUM];
  logic [23:0]      datain_w;
  logic [23:0]      rd_ages;
  logic             hazard;
  logic             accept;
  logic             s1_write;

  assign datain_w = {i_lru_buffer_datain7, i_lru_buffer_datain6,
                     i_lru_buffer_datain5, i_lru_buffer_datain4,
                     i_lru_buffer_datain3, i_lru_buffer_datain2,
                     i_lru_buffer_datain1, i_lru_buffer_datain0};

  assign hazard   = s1_valid && o_lru_write_enable && (s1_set == i_req_set);
  assign accept   = i_req_valid && o_req_ready;
  assign s1_write = s1_valid && o_lru_write_enable && !i_flush;

  // Request acceptance: closed during INIT and flush; without bypass also
  // closed for one cycle while S1 is rewriting the requested set.
  always_comb begin
`ifdef LRU_BYPASS_EN
    o_req_ready = (state == RUN) && !i_flush;
`else
    o_req_ready = (state == RUN) && !i_flush && !hazard;
`endif
  end

  // Data captured at accept: array read, or the in-flight next ages when
  // the array copy of this set is about to be overwritten by S1.
  always_comb begin
    rd_ages = ages_mem[i_req_set];
`ifdef LRU_BYPASS_EN
    if (hazard) rd_ages = datain_w;
`endif
  end

  // Control FSM and S1 pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= INIT;
      sweep_cnt          <= '0;
      s1_valid           <= 1'b0;
      s1_set             <= '0;
      o_lru_write_enable <= 1'b0;
      o_hit_sig          <= 1'b0;
      o_hit_way_8        <= '0;
      ages_q             <= '0;
    end else if (i_flush) begin
      state              <= INIT;
      sweep_cnt          <= '0;
      s1_valid           <= 1'b0;
      o_lru_write_enable <= 1'b0;
    end else begin
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == IDX_W'(SET_NUM - 1)) state <= RUN;
      end
      s1_valid           <= accept;
      o_lru_write_enable <= accept && i_req_update;
      if (accept) begin
        s1_set      <= i_req_set;
        o_hit_sig   <= i_req_hit;
        o_hit_way_8 <= i_req_hit_way_8;
        ages_q      <= rd_ages;
      end
    end
  end

  // Age array write port: sweep initialisation or S1 write-back.
  always_ff @(posedge clk) begin
    if (state == INIT && !i_flush) begin
      ages_mem[sweep_cnt] <= INIT_AGES;
    end else if (s1_write) begin
      ages_mem[s1_set] <= datain_w;
    end
  end

  assign o_resp_valid    = s1_valid && !i_flush;
  assign o_resp_victim_8 = s1_valid ? i_lru_flag : '0;
  assign o_init_busy     = (state == INIT);

  assign o_lru_buffer0 = ages_q[2:0];
  assign o_lru_buffer1 = ages_q[5:3];
  assign o_lru_buffer2 = ages_q[8:6];
  assign o_lru_buffer3 = ages_q[11:9];
  assign o_lru_buffer4 = ages_q[14:12];
  assign o_lru_buffer5 = ages_q[17:15];
  assign o_lru_buffer6 = ages_q[20:18];
  assign o_lru_buffer7 = ages_q[23:21];

endmodule

// File: doc/lru_state_table.md
LRU_STATE_TABLE -- requirements
Module: lru_state_table

Interface
REQ-001 SET_NUM, 16, number of cache sets tracked; power of two, at least 2.
REQ-002 IDX_W, 4, set-index width; equals log2(SET_NUM).
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_flush  input  1  restart table initialisation.
REQ-006 i_req_valid  input  1  access request present.
REQ-007 o_req_ready  output  1  request accepted when valid and ready are both high.
REQ-008 i_req_set  input  IDX_W  set index of the access.
REQ-009 i_req_hit  input  1  1 = hit, 0 = miss.
REQ-010 i_req_hit_way_8  input  8  one-hot hit way; ignored on miss.
REQ-011 i_req_update  input  1  write back the updated ages for this access.
REQ-012 o_hit_way_8 / o_hit_sig / o_lru_write_enable  output  8/1/1  S1 copies of request fields, sent to the age calculator.
REQ-013 o_lru_buffer0..o_lru_buffer7  output  3 each  current per-way ages of the S1 set; 7 = MRU, 0 = LRU.
REQ-014 i_lru_buffer_datain0..i_lru_buffer_datain7  input  3 each  next ages returned by the calculator.
REQ-015 i_lru_flag  input  8  one-hot LRU way returned by the calculator.
REQ-016 o_resp_valid  output  1  one-cycle response strobe; there is no back-pressure.
REQ-017 o_resp_victim_8  output  8  one-hot victim way (i_lru_flag sampled in S1).
REQ-018 o_init_busy  output  1  initialisation sweep in progress.

Function
REQ-019 Storage: SET_NUM x 8 x 3-bit ages, held in a synchronous-read array; the read address is registered at request accept.
REQ-020 States: INIT and RUN.
- INIT writes ages {0,1,2,3,4,5,6,7} (way i = i) to one set per cycle, from set 0 upward.
- INIT goes to RUN after set SET_NUM-1 is written, so INIT lasts exactly SET_NUM cycles.
REQ-021 o_init_busy = (state == INIT); o_req_ready = 0 in INIT and whenever i_flush = 1.
REQ-022 Pipeline:
- Accept in cycle T.
- Cycle T+1 (S1): o_lru_buffer* show the ages of the set, o_hit_way_8/o_hit_sig/o_lru_write_enable show the request fields, o_resp_valid = 1, o_resp_victim_8 = i_lru_flag.
REQ-023 At the end of S1, if o_lru_write_enable = 1, i_lru_buffer_datain0..7 are written to that set.
REQ-024 Throughput: one request per cycle when there is no hazard.
REQ-025 Hazard: the S1 set equals the newly accepted set and S1 is writing; handled per REQ-032/REQ-033.
REQ-026 Flush:
- i_flush kills S1: no write, o_resp_valid = 0.
- Next cycle: state INIT, sweep counter 0.
- i_flush during INIT restarts the counter at 0.
REQ-027 The block does not check that i_req_hit_way_8 is one-hot; it passes the value through unchanged.
REQ-028 With S1 empty, o_lru_buffer* hold their last values and o_lru_write_enable = 0.

Reset
REQ-029 While rst = 0: state INIT, sweep counter 0, S1 empty.
REQ-030 While rst = 0: o_req_ready = 0, o_resp_valid = 0, o_lru_write_enable = 0, o_hit_sig = 0, o_hit_way_8 = 0, o_resp_victim_8 = 0, o_lru_buffer* = 0, o_init_busy = 1.
REQ-031 Array contents are not reset; they are valid only after the sweep completes. Reset asserted mid-operation discards the in-flight access with no write.

Configuration
REQ-032 LRU_BYPASS_EN defined: on a hazard, S1 forwards i_lru_buffer_datain* to the next S1 stage in place of the stale array read. o_req_ready stays high.
REQ-033 LRU_BYPASS_EN undefined: o_req_ready = 0 for the cycle in which i_req_set equals the S1 set and S1 is writing, so the request is accepted one cycle later.

Verification
REQ-034 Release reset with SET_NUM=16: o_init_busy high 16 cycles, then o_req_ready = 1. Access set 5 -> S1 o_lru_buffer0..7 = 0,1,2,3,4,5,6,7.
REQ-035 Hit on set 2, way 3 (0x08), with update:
- S1: o_hit_way_8 = 0x08, o_resp_victim_8 = 0x01.
- Next access to set 2 -> ages 0,1,2,7,3,4,5,6.
REQ-036 Miss on fresh set 9 with update -> victim 0x01. Re-access -> ages 7,0,1,2,3,4,5,6, victim 0x02.
REQ-037 Back-to-back accesses to set 4 (hit way0, then miss):
- With LRU_BYPASS_EN: second request accepted in the next cycle, sees ages 7,0,1,2,3,4,5,6, victim 0x02.
- Without LRU_BYPASS_EN: o_req_ready low for 1 cycle, same result.
REQ-038 i_flush asserted during an S1 update to set 3:
- No o_resp_valid, no write.
- o_init_busy high 16 cycles.
- Set 3 then reads 0..7.
REQ-039 Assert rst mid-stream with S1 valid: outputs drop to their reset values immediately (asynchronously). After release, the sweep repeats and all sets read 0..7.
